// File: rtl/sha_pkg.sv
// Shared SHA-256 types, sizes and sigma functions used by the schedule and round logic.
package sha_pkg;

    localparam int unsigned SHA_BLOCK_W = 512;
    localparam int unsigned SHA_WORDS   = 16;

    typedef logic [31:0] word_t;

    typedef enum logic {StIdle, StRun} sched_state_t;

    function automatic word_t sha_ror(input word_t x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic word_t sha_s0(input word_t x);
        return sha_ror(x, 7) ^ sha_ror(x, 18) ^ (x >> 3);
    endfunction

    function automatic word_t sha_s1(input word_t x);
        return sha_ror(x, 17) ^ sha_ror(x, 19) ^ (x >> 10);
    endfunction

    function automatic word_t sha_bs0(input word_t x);
        return sha_ror(x, 2) ^ sha_ror(x, 13) ^ sha_ror(x, 22);
    endfunction

    function automatic word_t sha_bs1(input word_t x);
        return sha_ror(x, 6) ^ sha_ror(x, 11) ^ sha_ror(x, 25);
    endfunction

endpackage

// File: rtl/sha_sched_expand.sv
// Combinational expansion of LANES new schedule words from the current 16-word window.
module sha_sched_expand
    import sha_pkg::*;
#(
    parameter int unsigned LANES = 2
) (
    input  logic [SHA_BLOCK_W-1:0] window,
    output logic [32*LANES-1:0]    new_words
);

    // Window words followed by the words produced this cycle, so later lanes can
    // pick up W[j-2] (and for wide builds W[j-7]) from earlier lanes.
    word_t ext [SHA_WORDS+LANES];

    always_comb begin
        for (int i = 0; i < int'(SHA_WORDS); i++) begin
            ext[i] = window[32*i +: 32];
        end
        for (int k = 0; k < int'(LANES); k++) begin
            ext[int'(SHA_WORDS) + k] = sha_s1(ext[14 + k]) + ext[9 + k]
                                     + sha_s0(ext[1 + k]) + ext[k];
        end
        new_words = '0;
        for (int k = 0; k < int'(LANES); k++) begin
            new_words[32*k +: 32] = ext[int'(SHA_WORDS) + k];
        end
    end

endmodule

// File: rtl/sha_msg_schedule.sv
// SHA-256 message schedule: loads one block, streams W[0..ROUNDS-1] LANES words per beat.
module sha_msg_schedule
    import sha_pkg::*;
#(
    parameter int unsigned LANES  = 2,
    parameter int unsigned ROUNDS = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_valid,
    output logic                   load_ready,
    input  logic [SHA_BLOCK_W-1:0] block_in,
    output logic                   w_valid,
    input  logic                   w_ready,
    output logic [32*LANES-1:0]    w_out,
    output logic [5:0]             w_index,
    output logic                   done
);

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8)) begin : g_bad_lanes
        $error("sha_msg_schedule: LANES must be 1, 2, 4 or 8");
    end
    if (ROUNDS < 16 || ROUNDS > 64 || (ROUNDS % LANES) != 0) begin : g_bad_rounds
        $error("sha_msg_schedule: ROUNDS must be 16..64 and a multiple of LANES");
    end

    localparam logic [5:0] LastT   = 6'(ROUNDS - LANES);
    localparam logic [5:0] LanesW  = 6'(LANES);

    sched_state_t           state_q, state_d;
    logic [SHA_BLOCK_W-1:0] window_q, window_d;
    logic [5:0]             t_q, t_d;
    logic                   done_q, done_d;
    logic [32*LANES-1:0]    new_words;
    logic                   accept, last_beat, load_fire;

    sha_sched_expand #(
        .LANES(LANES)
    ) u_expand (
        .window   (window_q),
        .new_words(new_words)
    );

    assign w_valid    = (state_q == StRun);
    assign accept     = w_valid && w_ready;
    assign last_beat  = (t_q == LastT);
    // Idle, or the final beat is leaving this cycle: a new block can follow without a bubble.
    assign load_ready = !w_valid || (accept && last_beat);
    assign load_fire  = load_valid && load_ready;

    always_comb begin
        state_d  = state_q;
        window_d = window_q;
        t_d      = t_q;
        done_d   = accept && last_beat;
        if (load_fire) begin
            state_d  = StRun;
            window_d = block_in;
            t_d      = '0;
        end else if (accept) begin
            window_d = {new_words, window_q[SHA_BLOCK_W-1:32*LANES]};
            t_d      = t_q + LanesW;
            if (last_beat) begin
                state_d = StIdle;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            window_q <= '0;
            t_q      <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            window_q <= window_d;
            t_q      <= t_d;
            done_q   <= done_d;
        end
    end

    assign w_out   = window_q[32*LANES-1:0];
    assign w_index = t_q;
    assign done    = done_q;

endmodule

// File: tb/tb_sha_msg_schedule.sv
// Self-checking bench for sha_msg_schedule: golden "abc" vectors, corner sequences, random blocks.
module tb_sha_msg_schedule;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, load_valid, w_ready, lv_m, one;
    logic [511:0] block_in;
    logic         load_ready, w_valid, done;
    logic [63:0]  w_out;
    logic [5:0]   w_index;

    logic         l1_lr, l1_v, l1_d, l4_lr, l4_v, l4_d, l8_lr, l8_v, l8_d;
    logic [31:0]  l1_w;
    logic [127:0] l4_w;
    logic [255:0] l8_w;
    logic [5:0]   l1_i, l4_i, l8_i;

    sha_msg_schedule #(.LANES(2), .ROUNDS(64)) dut (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
        .block_in(block_in), .w_valid(w_valid), .w_ready(w_ready), .w_out(w_out),
        .w_index(w_index), .done(done)
    );
    sha_msg_schedule #(.LANES(1), .ROUNDS(64)) dut_l1 (
        .clk(clk), .rst(rst), .load_valid(lv_m), .load_ready(l1_lr), .block_in(block_in),
        .w_valid(l1_v), .w_ready(one), .w_out(l1_w), .w_index(l1_i), .done(l1_d)
    );
    sha_msg_schedule #(.LANES(4), .ROUNDS(64)) dut_l4 (
        .clk(clk), .rst(rst), .load_valid(lv_m), .load_ready(l4_lr), .block_in(block_in),
        .w_valid(l4_v), .w_ready(one), .w_out(l4_w), .w_index(l4_i), .done(l4_d)
    );
    sha_msg_schedule #(.LANES(8), .ROUNDS(64)) dut_l8 (
        .clk(clk), .rst(rst), .load_valid(lv_m), .load_ready(l8_lr), .block_in(block_in),
        .w_valid(l8_v), .w_ready(one), .w_out(l8_w), .w_index(l8_i), .done(l8_d)
    );

    typedef struct {
        string       name;
        int          idx;
        logic [31:0] exp;
    } vec_t;

    vec_t        tbl [6];
    logic [31:0] exp_w [64];
    logic [31:0] gold  [64];
    logic [31:0] cap   [64];
    int          total, passes, fails;
    int          m_pos, beats, loads, dones_exp, dones_seen, cyc, last_beat_cyc, done_cyc;
    bit          m_active, m_done;
    int          ml_pos [3];
    int          ml_beats [3];
    int          ml_done [3];
    logic [511:0] abc, blk_b, rb;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Reference schedule straight from the SHA-256 definition.
    task automatic compute_sched(input logic [511:0] b);
        logic [31:0] s0, s1;
        for (int i = 0; i < 16; i++) exp_w[i] = b[32*i +: 32];
        for (int j = 16; j < 64; j++) begin
            s0 = rotr(exp_w[j-15], 7) ^ rotr(exp_w[j-15], 18) ^ (exp_w[j-15] >> 3);
            s1 = rotr(exp_w[j-2], 17) ^ rotr(exp_w[j-2], 19) ^ (exp_w[j-2] >> 10);
            exp_w[j] = s1 + exp_w[j-7] + s0 + exp_w[j-16];
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end else begin
            passes++;
        end
    endtask

    // One cycle of the main DUT against the model; entered and left at a falling edge.
    task automatic step(input logic lv, input logic wr, input logic [511:0] blk);
        logic exp_lr;
        load_valid = lv;
        w_ready    = wr;
        block_in   = blk;
        #1;
        exp_lr = !m_active || (wr && m_pos == 62);
        chk("load_ready", load_ready, exp_lr);
        chk("w_valid", w_valid, m_active);
        chk("done", done, m_done);
        if (m_active) begin
            chk("w_index", w_index, m_pos);
            chk("w_out", w_out, {exp_w[m_pos+1], exp_w[m_pos]});
        end
        if (done) begin
            dones_seen++;
            done_cyc = cyc;
        end
        m_done = 0;
        if (m_active && wr) begin
            cap[m_pos]   = w_out[31:0];
            cap[m_pos+1] = w_out[63:32];
            beats++;
            if (m_pos == 62) begin
                last_beat_cyc = cyc;
                m_active = 0;
                m_done = 1;
                dones_exp++;
            end
            m_pos += 2;
        end
        if (lv && exp_lr) begin
            compute_sched(blk);
            m_active = 1;
            m_pos = 0;
            loads++;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic drain(input int stall_pct, input int budget);
        for (int i = 0; i < budget; i++) begin
            step(1'b0, ($urandom_range(99) >= stall_pct), '0);
            if (!m_active && !m_done) break;
        end
        chk("drain_timeout", {m_active, m_done}, 0);
    endtask

    task automatic start_capture();
        for (int i = 0; i < 64; i++) cap[i] = '0;
        beats = 0;
    endtask

    task automatic check_abc(input string tag);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("%s_%s", tag, tbl[i].name), cap[tbl[i].idx], tbl[i].exp);
        end
        chk($sformatf("%s_beats", tag), beats, 32);
        chk($sformatf("%s_done_gap", tag), done_cyc - last_beat_cyc, 1);
    endtask

    task automatic lane_chk(input int li, input int lanes, input logic v, input logic [255:0] wo,
                            input logic [5:0] wi, input logic d);
        if (v) begin
            chk($sformatf("l%0d_index", lanes), wi, ml_pos[li]);
            for (int k = 0; k < lanes; k++) begin
                if (int'(wi) + k < 64)
                    chk($sformatf("l%0d_w%0d", lanes, int'(wi) + k), wo[32*k +: 32],
                        gold[int'(wi) + k]);
            end
            ml_pos[li] += lanes;
            ml_beats[li]++;
        end
        if (d) ml_done[li]++;
    endtask

    initial begin
        int l0, d0, e0;
        tbl[0] = '{"w0",  0,  32'h61626380};
        tbl[1] = '{"w15", 15, 32'h00000018};
        tbl[2] = '{"w16", 16, 32'h61626380};
        tbl[3] = '{"w17", 17, 32'h000f0000};
        tbl[4] = '{"w18", 18, 32'h7da86405};
        tbl[5] = '{"w63", 63, 32'h12b1edeb};
        total = 0; passes = 0; fails = 0;
        m_pos = 0; beats = 0; loads = 0; dones_exp = 0; dones_seen = 0; cyc = 0;
        last_beat_cyc = 0; done_cyc = 0; m_active = 0; m_done = 0;
        abc = '0;
        abc[31:0]    = 32'h61626380;
        abc[511:480] = 32'h00000018;
        compute_sched(abc);
        gold = exp_w;

        rst = 1'b1; load_valid = 1'b0; w_ready = 1'b0; lv_m = 1'b0; one = 1'b1; block_in = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_w_valid", w_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_load_ready", load_ready, 1);
        chk("rst_w_index", w_index, 0);
        chk("rst_w_out_known", $isunknown(w_out), 0);
        @(negedge clk);
        rst = 1'b0;

        // Wide and narrow builds stream the same "abc" schedule.
        for (int i = 0; i < 3; i++) begin
            ml_pos[i] = 0; ml_beats[i] = 0; ml_done[i] = 0;
        end
        block_in = abc;
        lv_m = 1'b1;
        @(negedge clk);
        lv_m = 1'b0;
        for (int c = 0; c < 75; c++) begin
            lane_chk(0, 1, l1_v, {224'b0, l1_w}, l1_i, l1_d);
            lane_chk(1, 4, l4_v, {128'b0, l4_w}, l4_i, l4_d);
            lane_chk(2, 8, l8_v, l8_w, l8_i, l8_d);
            @(negedge clk);
        end
        chk("l1_beats", ml_beats[0], 64);
        chk("l4_beats", ml_beats[1], 16);
        chk("l8_beats", ml_beats[2], 8);
        chk("l1_done", ml_done[0], 1);
        chk("l4_done", ml_done[1], 1);
        chk("l8_done", ml_done[2], 1);

        // "abc" with a consumer that never stalls.
        start_capture();
        step(1'b1, 1'b1, abc);
        drain(0, 60);
        check_abc("abc");

        // "abc" with roughly 30% stall cycles.
        start_capture();
        step(1'b1, 1'b1, abc);
        drain(30, 300);
        check_abc("abc_stall");

        // Load offered mid-stream is refused until the final beat, then taken with no gap.
        for (int i = 0; i < 16; i++) blk_b[32*i +: 32] = $urandom();
        step(1'b1, 1'b1, abc);
        for (int i = 0; i < 40 && m_pos < 20; i++) step(1'b0, 1'b1, '0);
        chk("midload_pos", m_pos, 20);
        l0 = loads;
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 1'b1, blk_b);
            if (loads != l0) break;
        end
        chk("midload_accepted", loads - l0, 1);
        chk("midload_last_beat", last_beat_cyc, cyc - 1);
        drain(0, 60);

        // Asynchronous reset in the middle of a block.
        step(1'b1, 1'b1, abc);
        for (int i = 0; i < 40 && m_pos < 34; i++) step(1'b0, 1'b1, '0);
        chk("rst_mid_pos", m_pos, 34);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_w_valid", w_valid, 0);
        chk("rst_mid_load_ready", load_ready, 1);
        chk("rst_mid_done", done, 0);
        m_active = 0; m_done = 0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_mid_done_after", done, 0);
        rst = 1'b0;
        start_capture();
        step(1'b1, 1'b1, abc);
        drain(0, 60);
        check_abc("abc_after_rst");

        // Random blocks, random load offers and random stalls.
        l0 = loads; d0 = dones_seen; e0 = dones_exp;
        for (int i = 0; i < 70000 && (loads - l0) < 1000; i++) begin
            for (int k = 0; k < 16; k++) rb[32*k +: 32] = $urandom();
            step(1'($urandom_range(1)), ($urandom_range(99) >= 30), rb);
        end
        drain(30, 400);
        chk("rand_blocks", loads - l0, 1000);
        chk("rand_done_count", dones_seen - d0, loads - l0);
        chk("rand_done_exp", dones_seen - d0, dones_exp - e0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
